// File: rtl/cam_yuv422_rgb_writer_if.sv
// Camera-side byte stream and frame-buffer write port of the YUV422 -> RGB writer.
// The writer connects through "master"; a camera model or frame-buffer monitor connects through "slave".
interface cam_yuv422_rgb_writer_if #(
   parameter int DW     = 8,
   parameter int ADDR_W = 17
);
   logic              vsync;
   logic              href;
   logic [7:0]        cam_data;
   logic              enable;
   logic [DW-1:0]     data;
   logic [ADDR_W-1:0] wraddress;
   logic              wren;
   logic              frame_done;
   logic              overflow;

   modport master (
      input  vsync, href, cam_data, enable,
      output data, wraddress, wren, frame_done, overflow
   );

   modport slave (
      output vsync, href, cam_data, enable,
      input  data, wraddress, wren, frame_done, overflow
   );
endinterface

// File: rtl/cam_yuv422_rgb_writer.sv
// Captures YUV422 camera lines, converts each 4-byte group to two RGB332/RGB565 pixels
// and writes them into a frame buffer, one pixel per clock.
module cam_yuv422_rgb_writer #(
   parameter int OUT_FMT  = 0,
   parameter int UV_FIRST = 0,
   parameter int H_PIXELS = 320,
   parameter int V_LINES  = 240,
   parameter int ADDR_W   = 17
) (
   input logic                     pclk,
   input logic                     rst_n,
   cam_yuv422_rgb_writer_if.master bus
);

   localparam int DW = (OUT_FMT == 0) ? 8 : 16;
   localparam int CW = 16;
   localparam logic [CW-1:0]     H_LIM  = CW'(H_PIXELS);
   localparam logic [CW-1:0]     V_LIM  = CW'(V_LINES);
   localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIXELS);

   typedef enum logic [1:0] {IDLE, ARMED, BLANK, LINE} state_t;

   state_t            state_q, state_d;
   logic              vsync_q, href_q;
   logic [1:0]        phase_q, phase_d;
   logic [CW-1:0]     col_q, col_d, line_q, line_d;
   logic [ADDR_W-1:0] line_base_q, line_base_d;
   logic              line_wr_q, line_wr_d;
   logic              overflow_q, overflow_d;
   logic              frame_done_q, frame_done_d;
   logic [7:0]        b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;

   logic              vld_p1_q, vld_p1_d, wr0_p1_q, wr0_p1_d, wr1_p1_q, wr1_p1_d;
   logic [7:0]        y0_p1_q, y0_p1_d, y1_p1_q, y1_p1_d, u_p1_q, u_p1_d, v_p1_q, v_p1_d;
   logic [ADDR_W-1:0] addr_p1_q, addr_p1_d;

   logic              vld_p2_q, vld_p2_d, wr0_p2_q, wr0_p2_d, wr1_p2_q, wr1_p2_d;
   logic [DW-1:0]     pix0_p2_q, pix0_p2_d, pix1_p2_q, pix1_p2_d;
   logic [ADDR_W-1:0] addr_p2_q, addr_p2_d;

   logic              pend1_q, pend1_d;
   logic              wren_q, wren_d;
   logic [DW-1:0]     data_q, data_d;
   logic [ADDR_W-1:0] wraddress_q, wraddress_d;

   logic              vs_fall, vs_rise, hr_rise, take;
   logic [1:0]        ph;

   function automatic logic [7:0] clamp8(input logic signed [11:0] x);
      if (x < 0)
         return 8'd0;
      else if (x > 12'sd255)
         return 8'd255;
      else
         return x[7:0];
   endfunction

   function automatic logic [DW-1:0] yuv_to_pix(input logic [7:0] y, input logic [7:0] u,
                                                input logic [7:0] v);
      logic signed [11:0] ys, us, vs, r, g, b;
      logic [7:0]         r8, g8, b8;
      ys = $signed({4'd0, y}) - 12'sd16;
      us = $signed({4'd0, u}) - 12'sd128;
      vs = $signed({4'd0, v}) - 12'sd128;
      r  = ys + vs + (vs >>> 2);
      g  = ys - (us >>> 2) - (vs >>> 1);
      b  = ys + (us <<< 1);
      r8 = clamp8(r);
      g8 = clamp8(g);
      b8 = clamp8(b);
      if (OUT_FMT == 0)
         return DW'({r8[7:5], g8[7:5], b8[7:6]});
      else
         return DW'({r8[7:3], g8[7:2], b8[7:3]});
   endfunction

   assign vs_fall = vsync_q & ~bus.vsync;
   assign vs_rise = bus.vsync & ~vsync_q;
   assign hr_rise = bus.href & ~href_q;
   // A line only opens on a real href rising edge; href already high when blanking ends is ignored.
   assign take    = ~bus.vsync & bus.href &
                    ((state_q == LINE) || ((state_q == BLANK) && hr_rise));

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      col_d        = col_q;
      line_d       = line_q;
      line_base_d  = line_base_q;
      line_wr_d    = line_wr_q;
      overflow_d   = overflow_q;
      frame_done_d = 1'b0;
      b0_d         = b0_q;
      b1_d         = b1_q;
      b2_d         = b2_q;
      vld_p1_d     = 1'b0;
      wr0_p1_d     = wr0_p1_q;
      wr1_p1_d     = wr1_p1_q;
      y0_p1_d      = y0_p1_q;
      y1_p1_d      = y1_p1_q;
      u_p1_d       = u_p1_q;
      v_p1_d       = v_p1_q;
      addr_p1_d    = addr_p1_q;
      ph           = (state_q == LINE) ? phase_q : 2'd0;

      case (state_q)
         IDLE: begin
            if (bus.vsync)
               state_d = ARMED;
         end
         ARMED: begin
            if (vs_fall) begin
               if (bus.enable) begin
                  state_d     = BLANK;
                  overflow_d  = 1'b0;
                  line_d      = '0;
                  line_base_d = '0;
                  line_wr_d   = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            if (vs_rise) begin
               state_d      = IDLE;
               frame_done_d = 1'b1;
            end else if (state_q == BLANK) begin
               if (take) begin
                  state_d = LINE;
                  col_d   = '0;
               end
            end else if (!bus.href) begin
               // End of line: any partial group is simply forgotten.
               state_d   = BLANK;
               phase_d   = 2'd0;
               line_wr_d = 1'b0;
               if (line_wr_q) begin
                  line_base_d = line_base_q + H_STEP;
                  line_d      = line_q + 1'b1;
               end
            end
         end
      endcase

      if (take) begin
         phase_d = ph + 2'd1;
         case (ph)
            2'd0: b0_d = bus.cam_data;
            2'd1: b1_d = bus.cam_data;
            2'd2: b2_d = bus.cam_data;
            default: begin
               if (UV_FIRST == 0) begin
                  y0_p1_d = b0_q;
                  u_p1_d  = b1_q;
                  y1_p1_d = b2_q;
                  v_p1_d  = bus.cam_data;
               end else begin
                  u_p1_d  = b0_q;
                  y0_p1_d = b1_q;
                  v_p1_d  = b2_q;
                  y1_p1_d = bus.cam_data;
               end
               vld_p1_d  = 1'b1;
               wr0_p1_d  = (col_q < H_LIM) && (line_q < V_LIM);
               wr1_p1_d  = ((col_q + 1'b1) < H_LIM) && (line_q < V_LIM);
               addr_p1_d = line_base_q + ADDR_W'(col_q);
               if (!((col_q + 1'b1) < H_LIM) || !(line_q < V_LIM))
                  overflow_d = 1'b1;
               if ((col_q < H_LIM) && (line_q < V_LIM))
                  line_wr_d = 1'b1;
               if (col_q < H_LIM)
                  col_d = col_q + 2'd2;
            end
         endcase
      end

      // p1 -> p2: colour conversion of both pixels of the group
      vld_p2_d  = vld_p1_q;
      wr0_p2_d  = wr0_p1_q;
      wr1_p2_d  = wr1_p1_q;
      pix0_p2_d = yuv_to_pix(y0_p1_q, u_p1_q, v_p1_q);
      pix1_p2_d = yuv_to_pix(y1_p1_q, u_p1_q, v_p1_q);
      addr_p2_d = addr_p1_q;

      // p2 -> output: pixel 0 in the first cycle, pixel 1 in the next
      pend1_d     = 1'b0;
      wren_d      = 1'b0;
      data_d      = data_q;
      wraddress_d = wraddress_q;
      if (vld_p2_q) begin
         pend1_d = 1'b1;
         if (wr0_p2_q) begin
            wren_d      = 1'b1;
            data_d      = pix0_p2_q;
            wraddress_d = addr_p2_q;
         end
      end else if (pend1_q && wr1_p2_q) begin
         wren_d      = 1'b1;
         data_d      = pix1_p2_q;
         wraddress_d = addr_p2_q + 1'b1;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         phase_q      <= 2'd0;
         col_q        <= '0;
         line_q       <= '0;
         line_base_q  <= '0;
         line_wr_q    <= 1'b0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
         vld_p1_q     <= 1'b0;
         wr0_p1_q     <= 1'b0;
         wr1_p1_q     <= 1'b0;
         vld_p2_q     <= 1'b0;
         wr0_p2_q     <= 1'b0;
         wr1_p2_q     <= 1'b0;
         pend1_q      <= 1'b0;
         wren_q       <= 1'b0;
         data_q       <= '0;
         wraddress_q  <= '0;
      end else begin
         state_q      <= state_d;
         vsync_q      <= bus.vsync;
         href_q       <= bus.href;
         phase_q      <= phase_d;
         col_q        <= col_d;
         line_q       <= line_d;
         line_base_q  <= line_base_d;
         line_wr_q    <= line_wr_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
         vld_p1_q     <= vld_p1_d;
         wr0_p1_q     <= wr0_p1_d;
         wr1_p1_q     <= wr1_p1_d;
         vld_p2_q     <= vld_p2_d;
         wr0_p2_q     <= wr0_p2_d;
         wr1_p2_q     <= wr1_p2_d;
         pend1_q      <= pend1_d;
         wren_q       <= wren_d;
         data_q       <= data_d;
         wraddress_q  <= wraddress_d;
      end
   end

   // Pure datapath registers: qualified by the valid/phase flags above, so no reset needed.
   always_ff @(posedge pclk) begin
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      b2_q      <= b2_d;
      y0_p1_q   <= y0_p1_d;
      y1_p1_q   <= y1_p1_d;
      u_p1_q    <= u_p1_d;
      v_p1_q    <= v_p1_d;
      addr_p1_q <= addr_p1_d;
      pix0_p2_q <= pix0_p2_d;
      pix1_p2_q <= pix1_p2_d;
      addr_p2_q <= addr_p2_d;
   end

   assign bus.data       = data_q;
   assign bus.wraddress  = wraddress_q;
   assign bus.wren       = wren_q;
   assign bus.frame_done = frame_done_q;
   assign bus.overflow   = overflow_q;

endmodule
